// File: rtl/tmr_pkg.sv
// Shared types for the TMR resync controller: FSM states, pair-flag bit positions and the replica-fault decode.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package tmr_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_MONITOR    = 3'd0,
        ST_CONFIRM    = 3'd1,
        ST_WAIT_QUIET = 3'd2,
        ST_RESET      = 3'd3,
        ST_SETTLE     = 3'd4,
        ST_LOCKOUT    = 3'd5
    } state_t;

    // Bit positions inside a 3-bit pairwise discrepancy vector
    localparam int PAIR_12 = 0;
    localparam int PAIR_23 = 1;
    localparam int PAIR_13 = 2;

    // Replica index encoding; REPLICA_NONE also covers multi-replica patterns
    typedef enum logic [1:0] {
        REPLICA_NONE = 2'd0,
        REPLICA_1    = 2'd1,
        REPLICA_2    = 2'd2,
        REPLICA_3    = 2'd3
    } replica_t;

    typedef struct packed {
        logic     multi;
        replica_t replica;
    } fault_class_t;

    // A single bad replica disagrees with both of the others, so exactly the
    // two pairs that contain it are flagged.
    localparam logic [2:0] PAT_R1 = (3'b001 << PAIR_12) | (3'b001 << PAIR_13);
    localparam logic [2:0] PAT_R2 = (3'b001 << PAIR_12) | (3'b001 << PAIR_23);
    localparam logic [2:0] PAT_R3 = (3'b001 << PAIR_23) | (3'b001 << PAIR_13);

    function automatic fault_class_t decode_pair(input logic [2:0] pair);
        fault_class_t c;
        c.multi   = 1'b0;
        c.replica = REPLICA_NONE;
        case (pair)
            3'b000:  c.multi   = 1'b0;
            PAT_R1:  c.replica = REPLICA_1;
            PAT_R2:  c.replica = REPLICA_2;
            PAT_R3:  c.replica = REPLICA_3;
            default: c.multi   = 1'b1;   // all three pairs or a lone pair flag
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tmr_resync_controller_if.sv
// Bundles the voter discrepancy flags, UART line taps and controller status into one port.
// Latency: n/a (wiring only).
// Backpressure: n/a; master drives flags/lines and observes status, slave (controller) the reverse.
interface tmr_resync_controller_if #(
    parameter int COUNT_W = 16
);
    logic [2:0]         trx_error;
    logic [2:0]         output_io_error;
    logic [2:0]         command_arrive_discrepancy;
    logic               rx;
    logic               tx_voted;
    logic               replica_rst;
    logic [1:0]         faulty_replica;
    logic               multi_fault;
    logic               resync_busy;
    logic               resync_done;
    logic               lockout;
    logic [COUNT_W-1:0] transient_count;
    logic [3:0]         resync_count;

    modport master (
        output trx_error, output_io_error, command_arrive_discrepancy, rx, tx_voted,
        input  replica_rst, faulty_replica, multi_fault, resync_busy, resync_done,
        input  lockout, transient_count, resync_count
    );

    modport slave (
        input  trx_error, output_io_error, command_arrive_discrepancy, rx, tx_voted,
        output replica_rst, faulty_replica, multi_fault, resync_busy, resync_done,
        output lockout, transient_count, resync_count
    );
endinterface

// File: rtl/tmr_quiet_detector.sv
// Counts consecutive cycles with both UART lines idle-high; quiet flags the cycle that completes the window.
// Latency: quiet is combinational on the QUIET_CYCLES-th consecutive idle cycle after clear.
// Backpressure: none; clear restarts the window.
// Ports: clk, rst (sync, active-low), clear, rx, tx_voted in; quiet out.
module tmr_quiet_detector #(
    parameter int QUIET_CYCLES = 12000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic rx,
    input  logic tx_voted,
    output logic quiet
);
    localparam int QW = $clog2(QUIET_CYCLES + 1);

    logic [QW-1:0] run_cnt;
    logic          line_idle;

    assign line_idle = rx & tx_voted;

    // Saturates one short of the window so quiet keeps asserting on an idle line.
    always_ff @(posedge clk) begin
        if (!rst || clear || !line_idle) begin
            run_cnt <= '0;
        end else if (run_cnt != QW'(QUIET_CYCLES - 1)) begin
            run_cnt <= run_cnt + QW'(1);
        end
    end

    assign quiet = line_idle && (run_cnt == QW'(QUIET_CYCLES - 1));

endmodule

// File: rtl/tmr_resync_controller.sv
// Classifies voter discrepancies and, on persistent divergence, resets all replicas in a quiet UART window.
// Latency: divergence declared PERSIST_CYCLES after first flag; all outputs registered.
// Backpressure: none; resync waits for QUIET_CYCLES idle line cycles, locks out after MAX_RESYNC resyncs.
// Ports: clk, rst (sync, active-low), bus (slave: flags/lines in, replica_rst/status/counters out).
module tmr_resync_controller
    import tmr_pkg::*;
#(
    parameter int PERSIST_CYCLES = 16,
    parameter int QUIET_CYCLES   = 12000,
    parameter int RESET_CYCLES   = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter int MAX_RESYNC     = 7,
    parameter int COUNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    tmr_resync_controller_if.slave  bus
);
    localparam int CNT_MAX_A = (PERSIST_CYCLES > RESET_CYCLES) ? PERSIST_CYCLES : RESET_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > SETTLE_CYCLES) ? CNT_MAX_A : SETTLE_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;      // persistence / reset / settle phase counter
    logic [2:0]         pair;
    logic               fault;
    fault_class_t       cls;
    logic               quiet;
    logic               quiet_clear;
    logic               confirm_hit;
    logic               resync_exit;
    logic               transient_hit;

    logic               replica_rst_q;
    replica_t           faulty_q;
    logic               multi_q;
    logic               busy_q;
    logic               done_q;
    logic               lockout_q;
    logic [COUNT_W-1:0] transient_q;
    logic [3:0]         resync_q;

    assign pair  = bus.trx_error | bus.output_io_error | bus.command_arrive_discrepancy;
    assign fault = |pair;
    assign cls   = decode_pair(pair);

    tmr_quiet_detector #(
        .QUIET_CYCLES (QUIET_CYCLES)
    ) u_quiet (
        .clk      (clk),
        .rst      (rst),
        .clear    (quiet_clear),
        .rx       (bus.rx),
        .tx_voted (bus.tx_voted),
        .quiet    (quiet)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_MONITOR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        quiet_clear   = 1'b0;
        confirm_hit   = 1'b0;
        resync_exit   = 1'b0;
        transient_hit = 1'b0;
        case (state)
            ST_MONITOR: begin
                if (fault) begin
                    state_nxt = ST_CONFIRM;
                    cnt_nxt   = CW'(1);
                end
            end
            ST_CONFIRM: begin
                // Pattern changes keep counting; the decode at confirmation wins.
                if (!fault) begin
                    state_nxt     = ST_MONITOR;
                    cnt_nxt       = '0;
                    transient_hit = 1'b1;
                end else if (cnt == CW'(PERSIST_CYCLES - 1)) begin
                    state_nxt   = ST_WAIT_QUIET;
                    cnt_nxt     = '0;
                    confirm_hit = 1'b1;
                    quiet_clear = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_WAIT_QUIET: begin
                // Flags clearing here do not cancel: the replicas already diverged.
                if (quiet) begin
                    state_nxt = ST_RESET;
                    cnt_nxt   = '0;
                end
            end
            ST_RESET: begin
                if (cnt == CW'(RESET_CYCLES - 1)) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    resync_exit = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = (resync_q == 4'(MAX_RESYNC - 1)) ? ST_LOCKOUT : ST_MONITOR;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_LOCKOUT: begin
                // No more resyncs; the counter only tells short faults from long ones.
                if (fault) begin
                    if (cnt != CW'(PERSIST_CYCLES)) begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end else begin
                    if ((cnt != '0) && (cnt != CW'(PERSIST_CYCLES))) begin
                        transient_hit = 1'b1;
                    end
                    cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_MONITOR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            replica_rst_q <= 1'b1;
            faulty_q      <= REPLICA_NONE;
            multi_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            lockout_q     <= 1'b0;
            transient_q   <= '0;
            resync_q      <= '0;
        end else begin
            replica_rst_q <= (state_nxt != ST_RESET);
            busy_q        <= (state_nxt == ST_WAIT_QUIET) || (state_nxt == ST_RESET) ||
                             (state_nxt == ST_SETTLE);
            lockout_q     <= (state_nxt == ST_LOCKOUT);
            done_q        <= resync_exit;
            if (confirm_hit) begin
                faulty_q <= cls.replica;
                multi_q  <= cls.multi;
            end else if (resync_exit) begin
                faulty_q <= REPLICA_NONE;
                multi_q  <= 1'b0;
            end
            if (transient_hit && (transient_q != '1)) begin
                transient_q <= transient_q + COUNT_W'(1);
            end
            if (resync_exit) begin
                resync_q <= resync_q + 4'd1;
            end
        end
    end

    assign bus.replica_rst     = replica_rst_q;
    assign bus.faulty_replica  = faulty_q;
    assign bus.multi_fault     = multi_q;
    assign bus.resync_busy     = busy_q;
    assign bus.resync_done     = done_q;
    assign bus.lockout         = lockout_q;
    assign bus.transient_count = transient_q;
    assign bus.resync_count    = resync_q;

endmodule

// File: tb/tb_tmr_resync_controller.sv
// Directed bench for tmr_resync_controller with a cycle-by-cycle behavioural reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_tmr_resync_controller;
    localparam int P  = 4;
    localparam int Q  = 10;
    localparam int RC = 4;
    localparam int SC = 8;
    localparam int MR = 2;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tmr_resync_controller_if #(.COUNT_W(CW)) bus();

    tmr_resync_controller #(
        .PERSIST_CYCLES (P),
        .QUIET_CYCLES   (Q),
        .RESET_CYCLES   (RC),
        .SETTLE_CYCLES  (SC),
        .MAX_RESYNC     (MR),
        .COUNT_W        (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the fault run length, a quiet-line run, and the cycle the replica
    // reset began; every output follows from those by plain arithmetic.
    int       cyc = 0;
    int       run = 0;
    int       quiet_run = 0;
    int       rst_at = -1;
    int       m_trans = 0;
    int       m_resyncs = 0;
    bit       busy = 0;
    bit       locked = 0;
    bit       m_done = 0;
    int       m_rep = 0;
    bit       m_multi = 0;

    always @(posedge clk) begin : model
        logic [2:0] p;
        int ones;
        p = bus.trx_error | bus.output_io_error | bus.command_arrive_discrepancy;
        cyc++;
        m_done = 0;
        if (!rst) begin
            run = 0; quiet_run = 0; rst_at = -1; m_trans = 0; m_resyncs = 0;
            busy = 0; locked = 0; m_rep = 0; m_multi = 0;
        end else if (locked) begin
            if (p != 0) begin
                if (run < P) run++;
            end else begin
                if (run > 0 && run < P && m_trans < 2**CW - 1) m_trans++;
                run = 0;
            end
        end else if (!busy) begin
            if (p != 0) begin
                run++;
                if (run == P) begin
                    busy = 1; quiet_run = 0; rst_at = -1; run = 0;
                    ones = p[0] + p[1] + p[2];
                    // with two pairs flagged, the bad replica is the one absent from the clear pair
                    if (ones == 2) begin
                        m_multi = 0;
                        m_rep = !p[1] ? 1 : (!p[2] ? 2 : 3);
                    end else begin
                        m_multi = 1;
                        m_rep = 0;
                    end
                end
            end else begin
                if (run > 0 && m_trans < 2**CW - 1) m_trans++;
                run = 0;
            end
        end else if (rst_at < 0) begin
            if (bus.rx && bus.tx_voted) quiet_run++;
            else quiet_run = 0;
            if (quiet_run == Q) rst_at = cyc;
        end else if (cyc - rst_at == RC + SC) begin
            busy = 0; m_rep = 0; m_multi = 0; m_done = 1; run = 0; rst_at = -1;
            m_resyncs++;
            if (m_resyncs == MR) locked = 1;
        end
        #1;
        chk("replica_rst", bus.replica_rst, (busy && rst_at >= 0 && cyc - rst_at < RC) ? 0 : 1);
        chk("faulty_replica", bus.faulty_replica, m_rep);
        chk("multi_fault", bus.multi_fault, m_multi);
        chk("resync_busy", bus.resync_busy, busy);
        chk("resync_done", bus.resync_done, m_done);
        chk("lockout", bus.lockout, locked);
        chk("transient_count", bus.transient_count, m_trans);
        chk("resync_count", bus.resync_count, m_resyncs);
    end

    // ---------------- helpers ----------------
    task automatic wait_busy(input string name, input int budget, output int waited);
        waited = 0;
        while (bus.resync_busy !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        chk({name, "_busy_timeout"}, bus.resync_busy, 1);
    endtask

    task automatic wait_fall(input string name, input int budget, output int waited);
        waited = 0;
        while (bus.replica_rst !== 1'b0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        chk({name, "_fall_timeout"}, bus.replica_rst, 0);
    endtask

    // Called on the cycle replica_rst is first seen low: clears flags, then
    // measures pulse width and the distance to resync_done.
    task automatic measure_resync(input string name);
        int k;
        int low;
        bus.trx_error = 0; bus.output_io_error = 0; bus.command_arrive_discrepancy = 0;
        k = 0;
        low = 1;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (bus.replica_rst === 1'b0) low++;
            if (bus.resync_done === 1'b1) break;
        end
        chk({name, "_rst_low_cycles"}, low, RC);
        chk({name, "_done_after_fall"}, k, RC + SC);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int w;
        int k;
        bit low_seen;
        bus.trx_error = 0;
        bus.output_io_error = 0;
        bus.command_arrive_discrepancy = 0;
        bus.rx = 1;
        bus.tx_voted = 1;
        rst = 0;
        repeat (3) @(negedge clk);
        chk("reset_replica_rst", bus.replica_rst, 1);
        chk("reset_busy", bus.resync_busy, 0);
        chk("reset_lockout", bus.lockout, 0);
        chk("reset_transient", bus.transient_count, 0);
        chk("reset_resyncs", bus.resync_count, 0);
        rst = 1;

        // 1: three-cycle fault is a transient
        bus.trx_error = 3'b101;
        repeat (3) @(negedge clk);
        bus.trx_error = 0;
        repeat (3) @(negedge clk);
        chk("t1_transient", bus.transient_count, 1);
        chk("t1_replica_rst", bus.replica_rst, 1);
        chk("t1_busy", bus.resync_busy, 0);

        // 2: replica 3 diverges, lines already idle
        bus.output_io_error = 3'b110;
        wait_busy("t2", 20, w);
        chk("t2_confirm_latency", w, P);
        chk("t2_faulty", bus.faulty_replica, 3);
        chk("t2_multi", bus.multi_fault, 0);
        wait_fall("t2", 40, w);
        chk("t2_quiet_latency", w, Q);
        measure_resync("t2");
        chk("t2_resyncs", bus.resync_count, 1);

        // 3: multi fault while rx keeps breaking the quiet window
        bus.command_arrive_discrepancy = 3'b111;
        low_seen = 0;
        for (int i = 0; i < 50; i++) begin
            bus.rx = (i % 6 == 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (bus.replica_rst === 1'b0) low_seen = 1;
        end
        chk("t3_no_early_reset", low_seen, 0);
        chk("t3_multi", bus.multi_fault, 1);
        chk("t3_faulty", bus.faulty_replica, 0);
        bus.rx = 0;
        @(negedge clk);
        bus.rx = 1;
        wait_fall("t3", 40, w);
        chk("t3_quiet_latency", w, Q);
        measure_resync("t3");
        chk("t3_resyncs", bus.resync_count, 2);
        @(negedge clk);
        chk("t3_lockout", bus.lockout, 1);
        chk("t3_multi_cleared", bus.multi_fault, 0);

        // 4: lockout ignores persistent faults, still counts transients up to saturation
        bus.trx_error = 3'b011;
        low_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.replica_rst === 1'b0) low_seen = 1;
        end
        bus.trx_error = 0;
        repeat (2) @(negedge clk);
        chk("t4_no_reset", low_seen, 0);
        chk("t4_transient_same", bus.transient_count, 1);
        bus.trx_error = 3'b001;
        repeat (2) @(negedge clk);
        bus.trx_error = 0;
        repeat (2) @(negedge clk);
        chk("t4_transient_inc", bus.transient_count, 2);
        repeat (15) begin
            bus.output_io_error = 3'b010;
            @(negedge clk);
            bus.output_io_error = 0;
            @(negedge clk);
        end
        chk("t4_transient_sat", bus.transient_count, 2**CW - 1);
        chk("t4_still_locked", bus.lockout, 1);

        // 5: reset mid-RESET phase
        rst = 0;
        @(negedge clk);
        rst = 1;
        chk("t5_unlocked", bus.lockout, 0);
        bus.trx_error = 3'b110;
        @(negedge clk);
        bus.trx_error = 0;
        @(negedge clk);
        chk("t5_transient", bus.transient_count, 1);
        bus.output_io_error = 3'b101;
        wait_fall("t5", 40, w);
        rst = 0;
        bus.output_io_error = 0;
        @(negedge clk);
        chk("t5_replica_rst", bus.replica_rst, 1);
        chk("t5_busy", bus.resync_busy, 0);
        chk("t5_transient_clr", bus.transient_count, 0);
        chk("t5_faulty_clr", bus.faulty_replica, 0);
        rst = 1;
        @(negedge clk);

        // 6: pattern change inside CONFIRM keeps the latency, last pattern wins
        bus.trx_error = 3'b011;
        k = 0;
        repeat (2) begin
            @(negedge clk);
            k++;
        end
        bus.trx_error = 3'b101;
        wait_busy("t6", 20, w);
        chk("t6_latency", k + w, P);
        chk("t6_faulty", bus.faulty_replica, 1);
        chk("t6_multi", bus.multi_fault, 0);
        bus.trx_error = 0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmr_resync_controller.md
# tmr_resync_controller

Supervises the three redundant `control_module` replicas behind the majority voters. It combines the pairwise discrepancy flags from the TRX, output-IO and command-arrive voters and classifies the fault. A fault that persists is treated as replica state divergence: the controller waits for a quiet serial window, then resets all three replicas together so they restart in lockstep. It sits beside the voters in the top level and drives the replicas' shared reset.

## Interface
- `PERSIST_CYCLES`, 16: consecutive faulty cycles needed to declare divergence.
- `QUIET_CYCLES`, 12000: consecutive cycles with `rx` and `tx_voted` both high needed before a resync (> 1 UART frame at 125 MHz / 115200 baud).
- `RESET_CYCLES`, 4: length of the replica reset pulse.
- `SETTLE_CYCLES`, 8: cycles after reset during which flags are ignored.
- `MAX_RESYNC`, 7: number of resyncs after which the controller locks out.
- `COUNT_W`, 16: width of the statistic counters.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset.
- `trx_error` in 3: pairwise TRX flags; bit0 = 1≠2, bit1 = 2≠3, bit2 = 1≠3.
- `output_io_error` in 3: pairwise output-IO flags, same encoding.
- `command_arrive_discrepancy` in 3: pairwise command flags, same encoding.
- `rx` in 1: raw UART receive line.
- `tx_voted` in 1: voted UART transmit line.
- `replica_rst` out 1: active-low reset to all three replicas (ANDed with `rst` at top level).
- `faulty_replica` out 2: latched classification; 0 = none/multi, 1..3 = replica index.
- `multi_fault` out 1: latched; set when the pattern is not a single-replica pattern.
- `resync_busy` out 1: high in WAIT_QUIET, RESET and SETTLE.
- `resync_done` out 1: one-cycle pulse on return to MONITOR after a resync.
- `lockout` out 1: resync budget exhausted.
- `transient_count` out COUNT_W: saturating count of faults that cleared before confirmation.
- `resync_count` out 4: number of resyncs performed.

## Operation
- `pair = trx_error | output_io_error | command_arrive_discrepancy` (bitwise).
- Decode of `pair`:
  - 3'b101 → replica 1.
  - 3'b011 → replica 2.
  - 3'b110 → replica 3.
  - 3'b111 or any single bit set → multi.
  - 0 → no fault.
- States: MONITOR, CONFIRM, WAIT_QUIET, RESET, SETTLE, LOCKOUT.
- MONITOR:
  - `pair≠0` → CONFIRM, with the persistence counter loaded to 1.
- CONFIRM:
  - Persistence counter increments on each cycle with `pair≠0`.
  - `pair==0` → MONITOR and `transient_count`++ (saturating).
  - Counter reaching PERSIST_CYCLES → WAIT_QUIET.
  - On that transition, `faulty_replica` and `multi_fault` latch the decode of the current cycle.
- WAIT_QUIET:
  - Quiet counter increments while `rx & tx_voted`; it clears on either line low.
  - Reaching QUIET_CYCLES → RESET.
  - Flags clearing in this state do not cancel the resync.
- RESET:
  - `replica_rst=0` for exactly RESET_CYCLES cycles → SETTLE.
- SETTLE:
  - Flags are ignored for SETTLE_CYCLES cycles.
  - On exit, `resync_count`++ and `resync_done`=1 for one cycle.
  - Next state is MONITOR, or LOCKOUT if `resync_count` now equals MAX_RESYNC.
  - `faulty_replica` and `multi_fault` clear on exit.
- LOCKOUT:
  - `lockout=1` and `replica_rst=1`.
  - Transients are still counted.
  - Only `rst` leaves this state.

## Timing
- All outputs are registered.
- Reset values:
  - State MONITOR.
  - `replica_rst=1`.
  - `faulty_replica=0`, `multi_fault=0`.
  - `resync_busy=0`, `resync_done=0`, `lockout=0`.
  - Both counters 0.
- A flag asserted at edge n with `pair` constant: WAIT_QUIET is entered at edge n+PERSIST_CYCLES, and `faulty_replica` is valid the same cycle.
- With lines already quiet: `replica_rst` falls QUIET_CYCLES cycles after WAIT_QUIET entry.
- `resync_done` pulses RESET_CYCLES+SETTLE_CYCLES cycles after `replica_rst` falls.
- A pattern change inside CONFIRM (e.g. 101→110) does not restart counting; the last pattern wins.
- `rst` low at any point, including mid-RESET, returns to reset values at the next edge.
- `transient_count` holds at 2^COUNT_W−1.

## Structure
- Shared package `tmr_pkg` holds:
  - The state enum.
  - The pair-flag bit positions.
  - The replica-index encoding.
  - A `decode_pair` function.
- One sub-module, `tmr_quiet_detector`:
  - Counts consecutive cycles with `rx & tx_voted`.
  - Parameter QUIET_CYCLES; outputs `quiet`.
  - Cleared by the controller on WAIT_QUIET entry.

## Test plan
Bench parameters: PERSIST_CYCLES=4, QUIET_CYCLES=10, RESET_CYCLES=4, SETTLE_CYCLES=8, MAX_RESYNC=2.
- `trx_error`=3'b101 for 3 cycles, then 0 → `transient_count`=1, `replica_rst` stays 1, state MONITOR.
- `output_io_error`=3'b110 held, lines high → `faulty_replica`=3, `replica_rst` low exactly 4 cycles, `resync_done` pulse 8 cycles later, `resync_count`=1.
- `command_arrive_discrepancy`=3'b111 held, `rx` toggling low every 6 cycles for 50 cycles, then idle → `multi_fault`=1, no reset until 10 consecutive quiet cycles.
- Two full resyncs → `lockout`=1; a third persistent fault → no `replica_rst` pulse, `transient_count` still increments on short faults.
- `rst` driven low during the RESET phase → next cycle `replica_rst`=1, all counters 0, MONITOR.
- `pair` 3'b011 then 3'b101 within CONFIRM → `faulty_replica`=1, latency unchanged (4 cycles from first flag).
